// File: rtl/stream_mux_pkg.sv
// Shared types and defaults for the stream_mux block (modes, output FSM states,
// default geometry, parity helper used when STREAM_MUX_PARITY_EN is defined).
package stream_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int DEF_NUM_CH = 31;
  localparam int DEF_DATA_W = 2;

  // Even parity over a zero-extended word; padding bits do not change the XOR.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arb.sv
// Round-robin arbiter: first requesting channel at or above rr_ptr, wrapping
// from NUM_CH-1 to 0. Produces a one-hot grant plus its encoded index.
module stream_mux_rr_arb
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [SEL_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  logic [SEL_W:0] pos_s;
  logic           found_s;

  // Scan every offset from rr_ptr; the extra bit in pos_s absorbs the wrap sum.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    pos_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pos_s = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (pos_s >= (SEL_W+1)'(NUM_CH)) begin
        pos_s = pos_s - (SEL_W+1)'(NUM_CH);
      end else begin
        pos_s = pos_s;
      end
      if (!found_s && in_valid[pos_s[SEL_W-1:0]]) begin
        found_s                   = 1'b1;
        grant[pos_s[SEL_W-1:0]]   = 1'b1;
        idx                       = pos_s[SEL_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    any = found_s;
  end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer with DIRECT and ROUND_ROBIN selection and a single
// output register stage. Optional out_parity port: define STREAM_MUX_PARITY_EN.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int  NUM_CH = DEF_NUM_CH,
  parameter int  DATA_W = DEF_DATA_W,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready,
  output logic                     sel_err
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic                     out_parity
`endif
);

  mode_e               mode_s;
  state_e              state_r;
  logic [SEL_W-1:0]    rr_ptr_r;
  logic [NUM_CH-1:0]   rr_grant_s;
  logic [SEL_W-1:0]    rr_idx_s;
  logic                rr_any_s;
  logic [NUM_CH-1:0]   grant_s;
  logic [SEL_W-1:0]    idx_s;
  logic                any_s;
  logic                sel_ok_s;
  logic                load_s;
  logic                sel_err_nxt_s;
  logic [SEL_W-1:0]    rr_next_s;
  logic [DATA_W-1:0]   data_sel_s;

  assign mode_s   = mode_e'(mode);
  assign sel_ok_s = ({1'b0, sel} < (SEL_W+1)'(NUM_CH));

  stream_mux_rr_arb #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_rr_arb (
    .in_valid (in_valid),
    .rr_ptr   (rr_ptr_r),
    .grant    (rr_grant_s),
    .idx      (rr_idx_s),
    .any      (rr_any_s)
  );

  // Grant selection for the current mode; an out-of-range sel grants nothing.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    any_s   = 1'b0;
    case (mode_s)
      MODE_RR: begin
        grant_s = rr_grant_s;
        idx_s   = rr_idx_s;
        any_s   = rr_any_s;
      end
      MODE_DIRECT: begin
        if (sel_ok_s) begin
          grant_s[sel] = in_valid[sel];
          idx_s        = sel;
          any_s        = in_valid[sel];
        end else begin
          grant_s = '0;
          idx_s   = '0;
          any_s   = 1'b0;
        end
      end
      default: begin
        grant_s = '0;
        idx_s   = '0;
        any_s   = 1'b0;
      end
    endcase
  end

  // Gating with rst_n keeps every in_ready low while reset is held.
  assign load_s        = any_s & ((state_r == ST_EMPTY) | out_ready) & rst_n;
  assign in_ready      = grant_s & {NUM_CH{load_s}};
  assign data_sel_s    = in_data[idx_s*DATA_W +: DATA_W];
  assign rr_next_s     = (idx_s == SEL_W'(NUM_CH-1)) ? '0 : idx_s + SEL_W'(1);
  assign sel_err_nxt_s = (mode_s == MODE_DIRECT) & ~sel_ok_s & (|in_valid);

  // Output FSM with its registered data/index/pointer/error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      rr_ptr_r   <= '0;
      sel_err    <= 1'b0;
`ifdef STREAM_MUX_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      sel_err <= sel_err_nxt_s;
      case (state_r)
        ST_EMPTY: begin
          if (load_s) begin
            state_r   <= ST_FULL;
            out_valid <= 1'b1;
          end else begin
            state_r   <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (load_s) begin
            state_r   <= ST_FULL;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            state_r   <= ST_EMPTY;
            out_valid <= 1'b0;
          end else begin
            state_r   <= ST_FULL;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
      if (load_s) begin
        out_data <= data_sel_s;
        out_ch   <= idx_s;
`ifdef STREAM_MUX_PARITY_EN
        out_parity <= even_parity(64'(data_sel_s));
`endif
        if (mode_s == MODE_RR) begin
          rr_ptr_r <= rr_next_s;
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end else begin
        out_data <= out_data;
        out_ch   <= out_ch;
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed vectors with literal expectations
// plus a behavioural model compared against the DUT on every falling clock edge.
module tb_stream_mux;

  localparam int N  = 31;
  localparam int DW = 2;
  localparam int SW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_ch;
  logic            out_ready;
  logic            sel_err;
`ifdef STREAM_MUX_PARITY_EN
  logic            out_parity;
`endif

  always #5 clk = ~clk;

  stream_mux #(.NUM_CH(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .sel_err   (sel_err)
`ifdef STREAM_MUX_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] g;
    g = '0;
    g[c] = 1'b1;
    return g;
  endfunction

  // Which channel the spec's rules pick this cycle, or -1 for none.
  function automatic int m_pick(input logic md, input int s, input logic [N-1:0] v, input int rr);
    if (md) begin
      for (int off = 0; off < N; off++) begin
        if (v[(rr + off) % N]) return (rr + off) % N;
      end
      return -1;
    end
    if (s < N && v[s]) return s;
    return -1;
  endfunction

  // Reference model state.
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_ch    = 0;
  int            m_rr    = 0;
  bit            m_serr  = 1'b0;
  int            m_p;
  logic [N-1:0]  exp_ready;

  always_comb begin
    m_p = m_pick(mode, int'(sel), in_valid, m_rr);
    exp_ready = '0;
    if (m_p >= 0 && (!m_valid || out_ready)) exp_ready = oh(m_p);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= 0;
      m_rr    <= 0;
      m_serr  <= 1'b0;
    end else begin
      if (m_p >= 0 && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_data  <= in_data[m_p*DW +: DW];
        m_ch    <= m_p;
        if (mode) m_rr <= (m_p + 1) % N;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
      m_serr <= (!mode) && (int'(sel) >= N) && (|in_valid);
    end
  end

  // Compare process: DUT against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("m_out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("m_out_data", 64'(out_data), 64'(m_data));
        chk("m_out_ch", 64'(out_ch), 64'(m_ch));
`ifdef STREAM_MUX_PARITY_EN
        chk("m_out_parity", 64'(out_parity), 64'(^m_data));
`endif
      end
      chk("m_sel_err", 64'(sel_err), 64'(m_serr));
      chk("m_in_ready", 64'(in_ready), 64'(exp_ready));
    end
  end

  task automatic drive(input logic md, input logic [SW-1:0] s, input logic [N-1:0] v, input logic ordy);
    #1;
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
  endtask

  task automatic set_ch(input int c, input logic [DW-1:0] val);
    in_data[c*DW +: DW] = val;
  endtask

  int rr_seq [4] = '{0, 5, 30, 0};
  int rr_dat [4] = '{1, 2, 3, 1};
  int rr_par [4] = '{1, 1, 0, 1};

  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = '0; in_valid = '1; in_data = '0; out_ready = 1'b0;
    #8;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    #4;
    in_valid = '0;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // DIRECT sel=12
    @(negedge clk); drive(1'b0, 5'd12, oh(12), 1'b1); set_ch(12, 2'b10);
    #1 chk("d12_in_ready", 64'(in_ready), 64'(oh(12)));
    @(negedge clk);
    chk("d12_out_valid", 64'(out_valid), 64'd1);
    chk("d12_out_data", 64'(out_data), 64'd2);
    chk("d12_out_ch", 64'(out_ch), 64'd12);

    // DIRECT sel=30, then out-of-range sel=31
    drive(1'b0, 5'd30, oh(30), 1'b1); set_ch(30, 2'b11);
    @(negedge clk);
    chk("d30_out_data", 64'(out_data), 64'd3);
    chk("d30_out_ch", 64'(out_ch), 64'd30);
    drive(1'b0, 5'd31, '1, 1'b1);
    #1 chk("d31_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("d31_sel_err", 64'(sel_err), 64'd1);
    chk("d31_drained", 64'(out_valid), 64'd0);
    drive(1'b0, 5'd31, '0, 1'b1);
    @(negedge clk);
    chk("d31_sel_err_pulse", 64'(sel_err), 64'd0);

    // ROUND_ROBIN over channels 0, 5, 30
    drive(1'b1, 5'd0, oh(0) | oh(5) | oh(30), 1'b1);
    set_ch(0, 2'b01); set_ch(5, 2'b10);
    #1 chk("rr_first_ready", 64'(in_ready), 64'(oh(0)));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_out_valid", 64'(out_valid), 64'd1);
      chk("rr_out_ch", 64'(out_ch), 64'(rr_seq[i]));
      chk("rr_out_data", 64'(out_data), 64'(rr_dat[i]));
`ifdef STREAM_MUX_PARITY_EN
      chk("rr_out_parity", 64'(out_parity), 64'(rr_par[i]));
`endif
    end

    // Backpressure for 4 cycles, then drain and load together
    drive(1'b1, 5'd0, oh(0) | oh(5) | oh(30), 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_out_ch", 64'(out_ch), 64'd0);
      chk("bp_out_data", 64'(out_data), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    drive(1'b1, 5'd0, oh(0) | oh(5) | oh(30), 1'b1);
    #1 chk("bp_release_ready", 64'(in_ready), 64'(oh(5)));
    @(negedge clk);
    chk("bp_release_valid", 64'(out_valid), 64'd1);
    chk("bp_release_ch", 64'(out_ch), 64'd5);

    // Asynchronous reset while FULL (rr_ptr is 6 here)
    drive(1'b1, 5'd0, '0, 1'b0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = '1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_ch", 64'(out_ch), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    #4;
    in_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 5'd0, oh(3) | oh(20), 1'b1);
    #1 chk("arst_rr_from0", 64'(in_ready), 64'(oh(3)));
    @(negedge clk);
    chk("arst_first_ch", 64'(out_ch), 64'd3);

    // DIRECT detour holds rr_ptr (4); RR resumes from it
    drive(1'b0, 5'd20, oh(3) | oh(20), 1'b1);
    @(negedge clk);
    chk("mix_direct_ch", 64'(out_ch), 64'd20);
    drive(1'b1, 5'd20, oh(3) | oh(20), 1'b1);
    @(negedge clk);
    chk("mix_rr_resume_ch", 64'(out_ch), 64'd20);
    @(negedge clk);
    chk("mix_rr_wrap_ch", 64'(out_ch), 64'd3);

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            N'($urandom & $urandom), 1'($urandom_range(0, 3) != 0));
      in_data = 62'({$urandom(), $urandom()});
      @(negedge clk);
    end
    drive(1'b1, 5'd0, '0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 31, meaning the number of input channels (legal range 2..64).
REQ-002 The block SHALL have parameter DATA_W, default 2, meaning the width of each channel's data.
REQ-003 The block SHALL have derived localparam SEL_W, equal to $clog2(NUM_CH), meaning the width of the channel index.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 selects DIRECT mode, 1 selects ROUND_ROBIN mode.
REQ-007 The block SHALL have port sel, input, SEL_W bits: the channel index used in DIRECT mode.
REQ-008 The block SHALL have port in_valid, input, NUM_CH bits: per-channel request.
REQ-009 The block SHALL have port in_data, input, NUM_CH*DATA_W bits: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have port in_ready, output, NUM_CH bits: per-channel accept, one-hot or zero.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the output register holds data.
REQ-012 The block SHALL have port out_data, output, DATA_W bits: the registered selected data.
REQ-013 The block SHALL have port out_ch, output, SEL_W bits: the index of the channel that sourced out_data.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-015 The block SHALL have port sel_err, output, 1 bit: one-cycle pulse on an out-of-range select.

Function
REQ-016 The block SHALL implement a two-state FSM: EMPTY when out_valid=0, and FULL when out_valid=1.
REQ-017 The block SHALL define load = grant_any & (state==EMPTY | out_ready), and on load SHALL capture data/index into the output register and enter FULL.
REQ-018 The block SHALL go from FULL to EMPTY when out_ready=1 and there is no load; simultaneous drain and load SHALL stay FULL with the new data, with no bubble.
REQ-019 The block SHALL have a latency of 1 cycle from an in_valid/in_ready handshake to out_valid.
REQ-020 The block SHALL drive in_ready[i] combinationally, equal to load & grant[i]; in_ready SHALL NOT depend on in_data.
REQ-021 In DIRECT mode, grant[sel] SHALL equal in_valid[sel] when sel<NUM_CH.
REQ-022 In DIRECT mode with sel>=NUM_CH, the block SHALL issue no grant and SHALL pulse sel_err for one cycle, registered, on each cycle in which any in_valid=1.
REQ-023 In ROUND_ROBIN mode, the block SHALL grant the first channel with in_valid=1 scanning upward from rr_ptr, wrapping from NUM_CH-1 to 0; sel SHALL be ignored.
REQ-024 On each ROUND_ROBIN load, rr_ptr SHALL become (granted index + 1) mod NUM_CH; otherwise rr_ptr SHALL hold.
REQ-025 rr_ptr SHALL hold in DIRECT mode and SHALL resume from its held value when mode returns to 1.
REQ-026 mode and sel SHALL be sampled every cycle; a change SHALL affect only the next grant and never the held output.
REQ-027 While FULL and out_ready=0, out_data and out_ch SHALL remain stable.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately set out_valid=0, out_data=0, out_ch=0, sel_err=0, rr_ptr=0, and state=EMPTY.
REQ-029 Reset during a pending transfer SHALL discard the held data without producing a handshake.
REQ-030 The block SHALL drive in_ready=0 while rst_n=0.

Configuration
REQ-031 Macro STREAM_MUX_PARITY_EN SHALL control a parity feature.
REQ-032 When STREAM_MUX_PARITY_EN is defined, the block SHALL add output out_parity, 1 bit, holding the even parity (XOR) of out_data, registered with it and reset to 0.
REQ-033 When STREAM_MUX_PARITY_EN is undefined, the out_parity port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-034 Package stream_mux_pkg SHALL hold the mode enum (MODE_DIRECT=0, MODE_RR=1), the FSM state enum (ST_EMPTY, ST_FULL), and the default NUM_CH/DATA_W constants.
REQ-035 Sub-module stream_mux_rr_arb SHALL take in_valid and rr_ptr and produce the one-hot grant and the encoded index; stream_mux SHALL instantiate it once.

Verification
REQ-036 DIRECT mode, sel=12, in_valid[12]=1, in_data ch12=2'b10, out_ready=1 -> in_ready[12]=1 in the same cycle; next cycle out_valid=1, out_data=2'b10, out_ch=12.
REQ-037 DIRECT mode, sel=30, ch30=2'b11 -> out_data=2'b11, out_ch=30; then sel=31 with in_valid=all ones -> no in_ready, sel_err=1 for exactly one cycle per requesting cycle, out_valid drains to 0.
REQ-038 ROUND_ROBIN mode, in_valid set for channels 0, 5 and 30 held, out_ready=1 -> out_ch sequence 0, 5, 30, 0 on consecutive cycles, with no bubbles.
REQ-039 Backpressure: out_ready=0 for 4 cycles while FULL -> out_data and out_ch stable and in_ready=0; releasing out_ready with a pending request -> drain and load occur in the same cycle.
REQ-040 Reset: rst_n deasserted asynchronously mid-FULL (not clock-aligned) -> out_valid=0, rr_ptr=0 immediately; the first ROUND_ROBIN grant after release starts from channel 0.
REQ-041 With STREAM_MUX_PARITY_EN defined, out_data=2'b01 -> out_parity=1; out_data=2'b11 -> out_parity=0.
